// File: rtl/sprite_blitter.sv
// sprite_blitter: scans an IMG_W x IMG_H image held in a synchronous-read ROM
// and streams one VGA pixel write per clock at a run-time origin, clipping
// anything that lands off-screen.
//
// Optional feature macro: TRANSPARENCY_EN
//   defined   -> a pixel whose ROM colour equals TRANSP_COLOUR is not plotted
//   undefined -> every in-bounds pixel is plotted
//
// Pipeline: the address for pixel k leaves in cycle k+1 after the accepted
// start. The ROM answers in cycle k+2, when the registered x/y/plot stage for
// the same pixel is also valid. colour is taken straight from rom_q because
// the ROM's own output register already supplies that cycle of delay.
module sprite_blitter #(
  parameter int IMG_W    = 80,
  parameter int IMG_H    = 40,
  parameter int ADDR_W   = 12,
  parameter int COLOUR_W = 9,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          x_org,
  input  logic [6:0]          y_org,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  // Handshake: start is a level request, accepted only when the FSM is IDLE
  // and no done pulse is being shown; busy is high from the cycle after the
  // accepted start until done; done is a single-cycle pulse one cycle after
  // the final pixel is plotted. There is no other acknowledge.

  // Counter widths; a one-pixel dimension still needs a 1-bit counter.
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // End-of-row and end-of-image are plain equality compares so that 1-wide
  // or 1-tall images wrap and terminate correctly.
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

`ifdef TRANSPARENCY_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [7:0]        x_org_r;
  logic [6:0]        y_org_r;
  logic              busy_r;
  logic              done_r;

  // Output stage: stg_live marks a real pixel, stg_in marks it on-screen.
  logic              stg_live;
  logic              stg_in;
  logic [7:0]        x_r;
  logic [6:0]        y_r;

  logic              accept;
  logic              last_col;
  logic              last_pix;
  logic [8:0]        x_sum;
  logic [7:0]        y_sum;
  logic              in_bounds;
  logic              is_transp;

  // Request acceptance and scan-position decode for the address being issued.
  always_comb begin
    accept    = (state == S_IDLE) && start && !done_r;
    last_col  = (col == COL_LAST);
    last_pix  = last_col && (row == ROW_LAST);
    // One extra bit on each sum so that wrap past 255 / 127 is still clipped.
    x_sum     = {1'b0, x_org_r} + 9'(col);
    y_sum     = {1'b0, y_org_r} + 8'(row);
    in_bounds = (x_sum < 9'(SCR_W)) && (y_sum < 8'(SCR_H));
  end

  // Control FSM plus column/row/address counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      rom_addr_r <= '0;
      x_org_r    <= '0;
      y_org_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (accept) begin
            x_org_r    <= x_org;
            y_org_r    <= y_org;
            col        <= '0;
            row        <= '0;
            rom_addr_r <= '0;
            busy_r     <= 1'b1;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Row-major image: the ROM address simply counts up, no multiply.
          rom_addr_r <= rom_addr_r + ADDR_W'(1);
          if (last_col) begin
            col <= '0;
            row <= last_pix ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
          if (last_pix) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Final pixel is in the output stage this cycle.
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Output stage: delay the scan coordinate one cycle to line up with rom_q.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stg_live <= 1'b0;
      stg_in   <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
    end else begin
      stg_live <= (state == S_SCAN);
      stg_in   <= (state == S_SCAN) && in_bounds;
      if (state == S_SCAN) begin
        // Low bits are passed on even for clipped pixels.
        x_r <= x_sum[7:0];
        y_r <= y_sum[6:0];
      end
    end
  end

  // Transparent pixels keep their slot in the stream but do not write.
  always_comb begin
    is_transp = TRANSP_ON && (rom_q == TRANSP_COLOUR);
  end

  assign rom_addr = rom_addr_r;
  assign x        = x_r;
  assign y        = y_r;
  assign colour   = stg_live ? rom_q : '0;
  assign plot     = stg_in && !is_transp;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: default 80x40 instance, a 4x2 instance
// for clipping / start handling / transparency, and a 1x1 instance.
module tb_sprite_blitter;

  logic clk;
  logic resetn;

  // Default-parameter instance
  logic        start_a;
  logic [7:0]  x_org_a;
  logic [6:0]  y_org_a;
  logic [11:0] rom_addr_a;
  logic [8:0]  rom_q_a;
  logic [7:0]  x_a;
  logic [6:0]  y_a;
  logic [8:0]  colour_a;
  logic        plot_a, busy_a, done_a;

  // 4x2 instance
  logic        start_b;
  logic [7:0]  x_org_b;
  logic [6:0]  y_org_b;
  logic [3:0]  rom_addr_b;
  logic [8:0]  rom_q_b;
  logic [7:0]  x_b;
  logic [6:0]  y_b;
  logic [8:0]  colour_b;
  logic        plot_b, busy_b, done_b;

  // 1x1 instance
  logic        start_c;
  logic [7:0]  x_org_c;
  logic [6:0]  y_org_c;
  logic [0:0]  rom_addr_c;
  logic [8:0]  rom_q_c;
  logic [7:0]  x_c;
  logic [6:0]  y_c;
  logic [8:0]  colour_c;
  logic        plot_c, busy_c, done_c;

  logic [8:0] rom_a [0:4095];
  logic [8:0] rom_b [0:15];
  logic [8:0] rom_c [0:1];

  int n_cmp;
  int n_bad;

  // Scoreboard of expected {x, y, colour} for the default blit
  logic [23:0] exp_q[$];

  // Capture of a 4x2 run
  logic [23:0] pb_q[$];
  int          pcyc_q[$];
  int          dcyc_q[$];
  logic [7:0]  xh [0:63];
  logic [6:0]  yh [0:63];
  logic        ph [0:63];

  sprite_blitter dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .x_org(x_org_a), .y_org(y_org_a),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a), .x(x_a), .y(y_a), .colour(colour_a),
    .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  sprite_blitter #(.IMG_W(4), .IMG_H(2), .ADDR_W(4)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .x_org(x_org_b), .y_org(y_org_b),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b), .x(x_b), .y(y_b), .colour(colour_b),
    .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  sprite_blitter #(.IMG_W(1), .IMG_H(1), .ADDR_W(1)) dut_c (
    .clk(clk), .resetn(resetn), .start(start_c), .x_org(x_org_c), .y_org(y_org_c),
    .rom_addr(rom_addr_c), .rom_q(rom_q_c), .x(x_c), .y(y_c), .colour(colour_c),
    .plot(plot_c), .busy(busy_c), .done(done_c)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM models
  always @(posedge clk) begin
    rom_q_a <= rom_a[rom_addr_a];
    rom_q_b <= rom_b[rom_addr_b];
    rom_q_c <= rom_c[rom_addr_c];
  end

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rom_addr_a !== 12'd0) begin n_bad++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr_a); end
    n_cmp++; if ({x_a, y_a} !== 15'd0) begin n_bad++; $display("FAIL reset_xy got %0d,%0d want 0,0", x_a, y_a); end
    n_cmp++; if (colour_a !== 9'd0) begin n_bad++; $display("FAIL reset_colour got %h want 0", colour_a); end
    n_cmp++; if ({plot_a, busy_a, done_a} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {plot_a, busy_a, done_a}); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Full default blit at (39,39) with ROM[i] = i[8:0]
  task automatic test_default();
    int cyc, nplot, first_cyc, done_cyc, bad;
    logic [23:0] got, want, first_got, last_got;
    logic busy1;
    exp_q.delete();
    for (int k = 0; k < 3200; k++) exp_q.push_back({8'(39 + k % 80), 7'(39 + k / 80), 9'(k)});
    nplot = 0; first_cyc = -1; done_cyc = -1; bad = 0; first_got = '0; last_got = '0;
    x_org_a = 8'd39; y_org_a = 7'd39; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    busy1 = busy_a;
    for (cyc = 1; cyc < 3220 && done_cyc < 0; cyc++) begin
      if (plot_a === 1'b1) begin
        got = {x_a, y_a, colour_a};
        if (first_cyc < 0) begin first_cyc = cyc; first_got = got; end
        nplot++; last_got = got;
        if (exp_q.size() == 0) bad++;
        else begin want = exp_q.pop_front(); if (got !== want) bad++; end
      end
      if (done_a === 1'b1) done_cyc = cyc;
      else @(negedge clk);
    end
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL default_busy_c1 got %b want 1", busy1); end
    n_cmp++; if (nplot != 3200) begin n_bad++; $display("FAIL default_plot_count got %0d want 3200", nplot); end
    n_cmp++; if (first_cyc != 2) begin n_bad++; $display("FAIL default_first_cycle got %0d want 2", first_cyc); end
    n_cmp++; if (first_got !== {8'd39, 7'd39, 9'd0}) begin n_bad++; $display("FAIL default_first_pixel got %h want %h", first_got, {8'd39, 7'd39, 9'd0}); end
    n_cmp++; if (last_got !== {8'd118, 7'd78, 9'h07F}) begin n_bad++; $display("FAIL default_last_pixel got %h want %h", last_got, {8'd118, 7'd78, 9'h07F}); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL default_pixel_stream got %0d bad pixels want 0", bad); end
    n_cmp++; if (done_cyc != 3202) begin n_bad++; $display("FAIL default_done_cycle got %0d want 3202", done_cyc); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL default_busy_at_done got %b want 0", busy_a); end
    @(negedge clk);
    n_cmp++; if ({done_a, busy_a} !== 2'b00) begin n_bad++; $display("FAIL default_after_done got %b want 00", {done_a, busy_a}); end
  endtask

  // Reset during pixel 100, then confirm silence and a clean rerun
  task automatic test_reset_mid_blit();
    int nplot, ndone;
    x_org_a = 8'd39; y_org_a = 7'd39; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 1; cyc < 102; cyc++) @(negedge clk);
    n_cmp++; if ({plot_a, x_a, y_a} !== {1'b1, 8'd59, 7'd40}) begin n_bad++; $display("FAIL midreset_pixel100 got %b,%0d,%0d want 1,59,40", plot_a, x_a, y_a); end
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if ({plot_a, busy_a, done_a} !== 3'b000) begin n_bad++; $display("FAIL midreset_flags got %b want 000", {plot_a, busy_a, done_a}); end
    resetn = 1'b1;
    nplot = 0; ndone = 0;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge clk);
      if (plot_a === 1'b1) nplot++;
      if (done_a === 1'b1) ndone++;
    end
    n_cmp++; if ({nplot, ndone} != {32'd0, 32'd0}) begin n_bad++; $display("FAIL midreset_silence got plots %0d dones %0d want 0 0", nplot, ndone); end
    test_default();
  endtask

  // Drive the 4x2 instance and record its output every cycle
  task automatic run_b(input logic [7:0] xo, input logic [6:0] yo, input logic [63:0] mask,
                       input bit hold, input int budget);
    pb_q.delete(); pcyc_q.delete(); dcyc_q.delete();
    x_org_b = xo; y_org_b = yo;
    for (int cyc = 0; cyc < budget; cyc++) begin
      xh[cyc] = x_b; yh[cyc] = y_b; ph[cyc] = plot_b;
      if (plot_b === 1'b1) begin pb_q.push_back({x_b, y_b, colour_b}); pcyc_q.push_back(cyc); end
      if (done_b === 1'b1) dcyc_q.push_back(cyc);
      start_b = hold ? (dcyc_q.size() < 3) : mask[cyc];
      @(negedge clk);
    end
    start_b = 1'b0;
  endtask

  task automatic test_clip();
    logic [23:0] p0, p1;
    int c0, d0;
    for (int i = 0; i < 16; i++) rom_b[i] = 9'(i + 1);
    run_b(8'd158, 7'd119, 64'h1, 1'b0, 20);
    p0 = (pb_q.size() > 0) ? pb_q[0] : 24'hFFFFFF;
    p1 = (pb_q.size() > 1) ? pb_q[1] : 24'hFFFFFF;
    c0 = (pcyc_q.size() > 0) ? pcyc_q[0] : -1;
    d0 = (dcyc_q.size() > 0) ? dcyc_q[0] : -1;
    n_cmp++; if (pb_q.size() != 2) begin n_bad++; $display("FAIL clip_count got %0d want 2", pb_q.size()); end
    n_cmp++; if (p0 !== {8'd158, 7'd119, 9'd1}) begin n_bad++; $display("FAIL clip_first got %h want %h", p0, {8'd158, 7'd119, 9'd1}); end
    n_cmp++; if (p1 !== {8'd159, 7'd119, 9'd2}) begin n_bad++; $display("FAIL clip_second got %h want %h", p1, {8'd159, 7'd119, 9'd2}); end
    n_cmp++; if (c0 != 2) begin n_bad++; $display("FAIL clip_first_cycle got %0d want 2", c0); end
    n_cmp++; if ({ph[5], xh[5]} !== {1'b0, 8'd161}) begin n_bad++; $display("FAIL clip_x161 got %b,%0d want 0,161", ph[5], xh[5]); end
    n_cmp++; if ({ph[6], yh[6]} !== {1'b0, 7'd120}) begin n_bad++; $display("FAIL clip_y120 got %b,%0d want 0,120", ph[6], yh[6]); end
    n_cmp++; if (dcyc_q.size() != 1 || d0 != 10) begin n_bad++; $display("FAIL clip_done got %0d pulses first %0d want 1 at 10", dcyc_q.size(), d0); end
  endtask

  // Origin near the 8/7-bit limits: sums overflow, truncated bits still shown
  task automatic test_overflow();
    int d0;
    run_b(8'd255, 7'd127, 64'h1, 1'b0, 20);
    d0 = (dcyc_q.size() > 0) ? dcyc_q[0] : -1;
    n_cmp++; if (pb_q.size() != 0) begin n_bad++; $display("FAIL ovf_count got %0d want 0", pb_q.size()); end
    n_cmp++; if (xh[3] !== 8'd0) begin n_bad++; $display("FAIL ovf_x_wrap got %0d want 0", xh[3]); end
    n_cmp++; if (yh[6] !== 7'd0) begin n_bad++; $display("FAIL ovf_y_wrap got %0d want 0", yh[6]); end
    n_cmp++; if (d0 != 10) begin n_bad++; $display("FAIL ovf_done got %0d want 10", d0); end
  endtask

  task automatic test_busy_ignore();
    int d0;
    run_b(8'd10, 7'd10, 64'h49, 1'b0, 24);
    d0 = (dcyc_q.size() > 0) ? dcyc_q[0] : -1;
    n_cmp++; if (dcyc_q.size() != 1) begin n_bad++; $display("FAIL busy_ignore_dones got %0d want 1", dcyc_q.size()); end
    n_cmp++; if (d0 != 10) begin n_bad++; $display("FAIL busy_ignore_done_cycle got %0d want 10", d0); end
    n_cmp++; if (pb_q.size() != 8) begin n_bad++; $display("FAIL busy_ignore_plots got %0d want 8", pb_q.size()); end
  endtask

  task automatic test_back_to_back();
    int d0, d1, d2;
    run_b(8'd10, 7'd10, 64'h0, 1'b1, 50);
    d0 = (dcyc_q.size() > 0) ? dcyc_q[0] : -1;
    d1 = (dcyc_q.size() > 1) ? dcyc_q[1] : -1;
    d2 = (dcyc_q.size() > 2) ? dcyc_q[2] : -1;
    n_cmp++; if (dcyc_q.size() != 3) begin n_bad++; $display("FAIL b2b_dones got %0d want 3", dcyc_q.size()); end
    n_cmp++; if (d0 != 10) begin n_bad++; $display("FAIL b2b_first_done got %0d want 10", d0); end
    n_cmp++; if (d1 - d0 != 11 || d2 - d1 != 11) begin n_bad++; $display("FAIL b2b_spacing got %0d,%0d want 11,11", d1 - d0, d2 - d1); end
    n_cmp++; if (pb_q.size() != 24) begin n_bad++; $display("FAIL b2b_plots got %0d want 24", pb_q.size()); end
  endtask

  task automatic test_transparency();
    int want_n, even_plots, d0;
    logic [23:0] want_first, p0;
    for (int i = 0; i < 16; i++) rom_b[i] = (i % 2 == 1) ? 9'h1FF : 9'h000;
`ifdef TRANSPARENCY_EN
    want_n = 4; want_first = {8'd11, 7'd10, 9'h1FF};
`else
    want_n = 8; want_first = {8'd10, 7'd10, 9'h000};
`endif
    run_b(8'd10, 7'd10, 64'h1, 1'b0, 20);
    even_plots = 0;
    foreach (pb_q[i]) if (pb_q[i][16] == 1'b0) even_plots++;
    p0 = (pb_q.size() > 0) ? pb_q[0] : 24'hFFFFFF;
    d0 = (dcyc_q.size() > 0) ? dcyc_q[0] : -1;
    n_cmp++; if (pb_q.size() != want_n) begin n_bad++; $display("FAIL transp_count got %0d want %0d", pb_q.size(), want_n); end
    n_cmp++; if (p0 !== want_first) begin n_bad++; $display("FAIL transp_first got %h want %h", p0, want_first); end
    n_cmp++; if (even_plots != want_n - 4) begin n_bad++; $display("FAIL transp_even_cols got %0d want %0d", even_plots, want_n - 4); end
    n_cmp++; if (d0 != 10) begin n_bad++; $display("FAIL transp_done got %0d want 10", d0); end
  endtask

  task automatic test_single();
    int pl_cnt, pl_cyc, d_cnt, d_cyc;
    logic [23:0] got;
    logic busy1, busy_d;
    pl_cnt = 0; pl_cyc = -1; d_cnt = 0; d_cyc = -1; got = '0; busy1 = 1'b0; busy_d = 1'b1;
    x_org_c = 8'd0; y_org_c = 7'd0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 1) busy1 = busy_c;
      if (plot_c === 1'b1) begin pl_cnt++; pl_cyc = cyc; got = {x_c, y_c, colour_c}; end
      if (done_c === 1'b1) begin d_cnt++; d_cyc = cyc; busy_d = busy_c; end
      start_c = (cyc == 0);
      @(negedge clk);
    end
    start_c = 1'b0;
    n_cmp++; if (pl_cnt != 1 || pl_cyc != 2) begin n_bad++; $display("FAIL single_plot got %0d plots at %0d want 1 at 2", pl_cnt, pl_cyc); end
    n_cmp++; if (got !== {8'd0, 7'd0, 9'h155}) begin n_bad++; $display("FAIL single_pixel got %h want %h", got, {8'd0, 7'd0, 9'h155}); end
    n_cmp++; if (d_cnt != 1 || d_cyc != 3) begin n_bad++; $display("FAIL single_done got %0d pulses at %0d want 1 at 3", d_cnt, d_cyc); end
    n_cmp++; if ({busy1, busy_d} !== 2'b10) begin n_bad++; $display("FAIL single_busy got %b want 10", {busy1, busy_d}); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0;
    start_a = 1'b0; x_org_a = '0; y_org_a = '0;
    start_b = 1'b0; x_org_b = '0; y_org_b = '0;
    start_c = 1'b0; x_org_c = '0; y_org_c = '0;
    for (int i = 0; i < 4096; i++) rom_a[i] = 9'(i);
    for (int i = 0; i < 16; i++) rom_b[i] = 9'(i + 1);
    rom_c[0] = 9'h155; rom_c[1] = 9'h000;

    test_reset();
    test_default();
    test_reset_mid_blit();
    test_clip();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_transparency();
    test_single();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
